// File: rtl/gemm_tile_scheduler.sv
// gemm_tile_scheduler: walks the output tiles of C = A*B, sequencing operand
// SRAM reads, skewed FIFO push/pop into the PE array, drain and tile writeback.
module gemm_tile_scheduler #(
  parameter int OPND1_SRAM_AWIDTH = 10,
  parameter int OPND2_SRAM_AWIDTH = 10,
  parameter int OUT_SRAM_AWIDTH   = 10,
  parameter int PE_ARRAY_NUM_ROWS = 32,
  parameter int PE_ARRAY_NUM_COLS = 32,
  parameter int MAX_M_SIZE_LOG2   = 9,
  parameter int MAX_K_SIZE_LOG2   = 9,
  parameter int MAX_N_SIZE_LOG2   = 9,
  parameter int DRAIN_CYCLES      = 64
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             START,
  input  logic                             STALL,
  input  logic [MAX_M_SIZE_LOG2-1:0]       M_SIZE_in,
  input  logic [MAX_K_SIZE_LOG2-1:0]       K_SIZE_in,
  input  logic [MAX_N_SIZE_LOG2-1:0]       N_SIZE_in,
  output logic [OPND1_SRAM_AWIDTH-1:0]     OPND1_SRAM_ADDR_out,
  output logic                             OPND1_SRAM_REN_out,
  output logic [OPND2_SRAM_AWIDTH-1:0]     OPND2_SRAM_ADDR_out,
  output logic                             OPND2_SRAM_REN_out,
  output logic [PE_ARRAY_NUM_ROWS-1:0]     OPND1_FIFO_PUSH_out,
  output logic [PE_ARRAY_NUM_ROWS-1:0]     OPND1_FIFO_POP_out,
  output logic [PE_ARRAY_NUM_COLS-1:0]     OPND2_FIFO_PUSH_out,
  output logic [PE_ARRAY_NUM_COLS-1:0]     OPND2_FIFO_POP_out,
  output logic                             PE_CLEAR_out,
  output logic [$clog2(PE_ARRAY_NUM_ROWS)-1:0] PE_ROW_SEL_out,
  output logic [OUT_SRAM_AWIDTH-1:0]       OUT_SRAM_ADDR_out,
  output logic                             OUT_SRAM_WEN_out,
  output logic [PE_ARRAY_NUM_COLS-1:0]     OUT_SRAM_COL_MASK_out,
  output logic                             IS_FINISHED_out
);
  localparam int RW = $clog2(PE_ARRAY_NUM_ROWS);
  localparam logic [31:0] RU    = 32'(PE_ARRAY_NUM_ROWS);
  localparam logic [31:0] CU    = 32'(PE_ARRAY_NUM_COLS);
  localparam logic [31:0] MAXRC = (RU > CU) ? RU : CU;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                       r_state;
  logic [MAX_M_SIZE_LOG2-1:0]   r_m;
  logic [MAX_K_SIZE_LOG2-1:0]   r_k;
  logic [MAX_N_SIZE_LOG2-1:0]   r_n;
  logic [15:0]                  r_mtn, r_ntn, r_mt, r_nt, r_c;
  logic                         r_ren_d;
  logic [OPND1_SRAM_AWIDTH-1:0] r_a1;
  logic [OPND2_SRAM_AWIDTH-1:0] r_a2;
  logic [OUT_SRAM_AWIDTH-1:0]   r_oaddr;

  logic [31:0] w_c32, w_mrem, w_nrem, w_vr, w_vc, w_kend;
  logic        w_stream, w_write, w_ren, w_push, w_zero;
  logic [OPND1_SRAM_AWIDTH-1:0] w_a1;
  logic [OPND2_SRAM_AWIDTH-1:0] w_a2;
  logic [OUT_SRAM_AWIDTH-1:0]   w_oaddr;

  // Tile geometry and beat decode; products stay 32-bit until the port cast.
  assign w_c32    = 32'(r_c);
  assign w_mrem   = 32'(r_m) - 32'(r_mt) * RU;
  assign w_nrem   = 32'(r_n) - 32'(r_nt) * CU;
  assign w_vr     = (w_mrem > RU) ? RU : w_mrem;
  assign w_vc     = (w_nrem > CU) ? CU : w_nrem;
  assign w_kend   = 32'(r_k) + MAXRC;
  assign w_stream = (r_state == S_STREAM);
  assign w_write  = (r_state == S_WRITE);
  assign w_ren    = w_stream && (w_c32 < 32'(r_k)) && !STALL;
  assign w_push   = w_stream && r_ren_d && !STALL;
  assign w_zero   = (M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0);
  assign w_a1     = OPND1_SRAM_AWIDTH'(32'(r_mt) * 32'(r_k) + w_c32);
  assign w_a2     = OPND2_SRAM_AWIDTH'(32'(r_nt) * 32'(r_k) + w_c32);
  assign w_oaddr  = OUT_SRAM_AWIDTH'((32'(r_mt) * 32'(r_ntn) + 32'(r_nt)) * RU + w_c32);

  // Port strobes: decoded from frozen state, all gated off while stalled.
  assign OPND1_SRAM_REN_out  = w_ren;
  assign OPND2_SRAM_REN_out  = w_ren;
  assign OPND1_SRAM_ADDR_out = w_ren ? w_a1 : r_a1;
  assign OPND2_SRAM_ADDR_out = w_ren ? w_a2 : r_a2;
  assign PE_CLEAR_out        = (r_state == S_CLEAR) && !STALL;
  assign OUT_SRAM_WEN_out    = w_write && !STALL;
  assign OUT_SRAM_ADDR_out   = OUT_SRAM_WEN_out ? w_oaddr : r_oaddr;
  assign PE_ROW_SEL_out      = w_write ? r_c[RW-1:0] : '0;
  assign IS_FINISHED_out     = (r_state == S_DONE);

  // Row lanes: lane i pops one beat later than lane i-1 to form the wavefront.
  for (genvar i = 0; i < PE_ARRAY_NUM_ROWS; i++) begin : g_row
    assign OPND1_FIFO_PUSH_out[i] = w_push && (32'(i) < w_vr);
    assign OPND1_FIFO_POP_out[i]  = w_stream && !STALL && (32'(i) < w_vr) &&
                                    (w_c32 >= 32'(i) + 32'd2) &&
                                    (w_c32 <= 32'(r_k) + 32'(i) + 32'd1);
  end

  // Column lanes: same skew; the column mask follows the tile's valid width.
  for (genvar j = 0; j < PE_ARRAY_NUM_COLS; j++) begin : g_col
    assign OPND2_FIFO_PUSH_out[j]   = w_push && (32'(j) < w_vc);
    assign OPND2_FIFO_POP_out[j]    = w_stream && !STALL && (32'(j) < w_vc) &&
                                      (w_c32 >= 32'(j) + 32'd2) &&
                                      (w_c32 <= 32'(r_k) + 32'(j) + 32'd1);
    assign OUT_SRAM_COL_MASK_out[j] = OUT_SRAM_WEN_out && (32'(j) < w_vc);
  end

  // Sequencer: one step per unstalled beat; IDLE/DONE only watch START.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_m     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_mtn   <= '0;
      r_ntn   <= '0;
      r_mt    <= '0;
      r_nt    <= '0;
      r_c     <= '0;
      r_ren_d <= 1'b0;
      r_a1    <= '0;
      r_a2    <= '0;
      r_oaddr <= '0;
    end else begin
      if (w_ren) begin
        r_a1 <= w_a1;
        r_a2 <= w_a2;
      end
      if (OUT_SRAM_WEN_out) r_oaddr <= w_oaddr;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_m     <= M_SIZE_in;
            r_k     <= K_SIZE_in;
            r_n     <= N_SIZE_in;
            r_mtn   <= 16'((32'(M_SIZE_in) + RU - 32'd1) / RU);
            r_ntn   <= 16'((32'(N_SIZE_in) + CU - 32'd1) / CU);
            r_mt    <= '0;
            r_nt    <= '0;
            r_c     <= '0;
            r_ren_d <= 1'b0;
            r_state <= w_zero ? S_DONE : S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (!STALL) begin
            r_c     <= '0;
            r_ren_d <= 1'b0;
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (!STALL) begin
            r_ren_d <= (w_c32 < 32'(r_k));
            if (w_c32 == w_kend) begin
              r_c     <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_c <= r_c + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!STALL) begin
            if (w_c32 == 32'(DRAIN_CYCLES - 1)) begin
              r_c     <= '0;
              r_state <= S_WRITE;
            end else begin
              r_c <= r_c + 16'd1;
            end
          end
        end
        S_WRITE: begin
          if (!STALL) begin
            if (w_c32 == w_vr - 32'd1) begin
              r_c <= '0;
              if (r_nt + 16'd1 < r_ntn) begin
                r_nt    <= r_nt + 16'd1;
                r_state <= S_CLEAR;
              end else if (r_mt + 16'd1 < r_mtn) begin
                r_nt    <= '0;
                r_mt    <= r_mt + 16'd1;
                r_state <= S_CLEAR;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_c <= r_c + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Bench for gemm_tile_scheduler: a job-level model expands each START into the
// unstalled beat trace; the checker consumes one beat per unstalled cycle.
module tb_gemm_tile_scheduler;
  logic        CLK = 1'b0, RST = 1'b1, START = 1'b0, STALL = 1'b0;
  logic [8:0]  M_SIZE_in = '0, K_SIZE_in = '0, N_SIZE_in = '0;
  logic [9:0]  OPND1_SRAM_ADDR_out, OPND2_SRAM_ADDR_out, OUT_SRAM_ADDR_out;
  logic        OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, PE_CLEAR_out, OUT_SRAM_WEN_out, IS_FINISHED_out;
  logic [31:0] OPND1_FIFO_PUSH_out, OPND1_FIFO_POP_out, OPND2_FIFO_PUSH_out, OPND2_FIFO_POP_out, OUT_SRAM_COL_MASK_out;
  logic [4:0]  PE_ROW_SEL_out;

  always #5 CLK = ~CLK;

  gemm_tile_scheduler dut (
    .CLK(CLK), .RST(RST), .START(START), .STALL(STALL),
    .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in), .N_SIZE_in(N_SIZE_in),
    .OPND1_SRAM_ADDR_out(OPND1_SRAM_ADDR_out), .OPND1_SRAM_REN_out(OPND1_SRAM_REN_out),
    .OPND2_SRAM_ADDR_out(OPND2_SRAM_ADDR_out), .OPND2_SRAM_REN_out(OPND2_SRAM_REN_out),
    .OPND1_FIFO_PUSH_out(OPND1_FIFO_PUSH_out), .OPND1_FIFO_POP_out(OPND1_FIFO_POP_out),
    .OPND2_FIFO_PUSH_out(OPND2_FIFO_PUSH_out), .OPND2_FIFO_POP_out(OPND2_FIFO_POP_out),
    .PE_CLEAR_out(PE_CLEAR_out), .PE_ROW_SEL_out(PE_ROW_SEL_out),
    .OUT_SRAM_ADDR_out(OUT_SRAM_ADDR_out), .OUT_SRAM_WEN_out(OUT_SRAM_WEN_out),
    .OUT_SRAM_COL_MASK_out(OUT_SRAM_COL_MASK_out), .IS_FINISHED_out(IS_FINISHED_out)
  );

  typedef struct {
    bit        ren;  int a1;  int a2;
    bit [31:0] push1; bit [31:0] pop1; bit [31:0] push2; bit [31:0] pop2;
    bit        clr;  bit wen; int row; int oaddr; bit [31:0] cmask;
  } beat_t;

  beat_t q[$];
  int mode = 0;  // 0 idle, 1 busy, 2 done
  int checks = 0, errors = 0;
  int obs_ren = 0, obs_wen = 0, obs_pop31 = 0;
  int cur_ren = -1, cur_wen = -1, cur_pop31 = -1;
  int lit_qsize = -1, lit_ren = -1, lit_wen = -1, lit_pop31 = -1, lit_last = -1;
  bit [31:0] lit_mask = '0;

  // Expand a job into its unstalled beat sequence from the tiling rules.
  function automatic void build(int m, int k, int n);
    int mtn, ntn, vr, vc;
    beat_t b;
    q.delete();
    if (m == 0 || k == 0 || n == 0) return;
    mtn = (m + 31) / 32;
    ntn = (n + 31) / 32;
    for (int mt = 0; mt < mtn; mt++)
      for (int nt = 0; nt < ntn; nt++) begin
        vr = (m - mt * 32 < 32) ? m - mt * 32 : 32;
        vc = (n - nt * 32 < 32) ? n - nt * 32 : 32;
        b = '{default: 0}; b.clr = 1; q.push_back(b);
        for (int c = 0; c <= k + 32; c++) begin
          b = '{default: 0};
          b.ren = (c < k); b.a1 = (mt * k + c) % 1024; b.a2 = (nt * k + c) % 1024;
          for (int i = 0; i < 32; i++) begin
            b.push1[i] = (c >= 1 && c <= k && i < vr);
            b.push2[i] = (c >= 1 && c <= k && i < vc);
            b.pop1[i]  = (c >= 2 + i && c <= k + 1 + i && i < vr);
            b.pop2[i]  = (c >= 2 + i && c <= k + 1 + i && i < vc);
          end
          q.push_back(b);
        end
        for (int d = 0; d < 64; d++) begin b = '{default: 0}; q.push_back(b); end
        for (int r = 0; r < vr; r++) begin
          b = '{default: 0}; b.wen = 1; b.row = r;
          b.oaddr = ((mt * ntn + nt) * 32 + r) % 1024;
          for (int j = 0; j < 32; j++) b.cmask[j] = (j < vc);
          q.push_back(b);
        end
      end
  endfunction

  // Checker + model step: compare this cycle, then advance on the inputs the next edge samples.
  always @(negedge CLK) begin
    bit    ok, sz;
    beat_t e;
    string nm;
    e  = '{default: 0};
    sz = !OPND1_SRAM_REN_out && !OPND2_SRAM_REN_out && OPND1_FIFO_PUSH_out == 0 &&
         OPND1_FIFO_POP_out == 0 && OPND2_FIFO_PUSH_out == 0 && OPND2_FIFO_POP_out == 0 &&
         !PE_CLEAR_out && !OUT_SRAM_WEN_out;
    if (mode == 0) begin
      nm = "idle";
      ok = sz && !IS_FINISHED_out && OPND1_SRAM_ADDR_out == 0 && OPND2_SRAM_ADDR_out == 0 &&
           OUT_SRAM_ADDR_out == 0 && PE_ROW_SEL_out == 0 && OUT_SRAM_COL_MASK_out == 0;
    end else if (mode == 2) begin
      nm = "done"; ok = sz && IS_FINISHED_out;
    end else if (STALL) begin
      nm = "stall"; ok = sz && !IS_FINISHED_out;
    end else begin
      nm = "beat"; e = q[0];
      ok = OPND1_SRAM_REN_out == e.ren && OPND2_SRAM_REN_out == e.ren &&
           (!e.ren || (int'(OPND1_SRAM_ADDR_out) == e.a1 && int'(OPND2_SRAM_ADDR_out) == e.a2)) &&
           OPND1_FIFO_PUSH_out == e.push1 && OPND1_FIFO_POP_out == e.pop1 &&
           OPND2_FIFO_PUSH_out == e.push2 && OPND2_FIFO_POP_out == e.pop2 &&
           PE_CLEAR_out == e.clr && OUT_SRAM_WEN_out == e.wen && !IS_FINISHED_out &&
           (!e.wen || (int'(PE_ROW_SEL_out) == e.row && int'(OUT_SRAM_ADDR_out) == e.oaddr &&
                       OUT_SRAM_COL_MASK_out == e.cmask));
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s t=%0t got ren=%b%b a1=%0d a2=%0d push1=%h pop1=%h push2=%h pop2=%h clr=%b wen=%b row=%0d oaddr=%0d mask=%h fin=%b | want ren=%b a1=%0d a2=%0d push1=%h pop1=%h push2=%h pop2=%h clr=%b wen=%b row=%0d oaddr=%0d mask=%h fin=%0d",
               nm, $time, OPND1_SRAM_REN_out, OPND2_SRAM_REN_out, OPND1_SRAM_ADDR_out, OPND2_SRAM_ADDR_out,
               OPND1_FIFO_PUSH_out, OPND1_FIFO_POP_out, OPND2_FIFO_PUSH_out, OPND2_FIFO_POP_out,
               PE_CLEAR_out, OUT_SRAM_WEN_out, PE_ROW_SEL_out, OUT_SRAM_ADDR_out, OUT_SRAM_COL_MASK_out,
               IS_FINISHED_out, e.ren, e.a1, e.a2, e.push1, e.pop1, e.push2, e.pop2, e.clr, e.wen,
               e.row, e.oaddr, e.cmask, (mode == 2));
    end
    if (mode == 1) begin
      obs_ren   += int'(OPND1_SRAM_REN_out);
      obs_wen   += int'(OUT_SRAM_WEN_out);
      obs_pop31 += int'(OPND1_FIFO_POP_out[31]);
    end
    if (RST) begin
      mode = 0; q.delete();
    end else if (mode == 1) begin
      if (!STALL) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          mode = 2;
          if (cur_ren >= 0) begin
            checks++;
            if (obs_ren != cur_ren) begin errors++; $display("FAIL ren_count got=%0d want=%0d", obs_ren, cur_ren); end
          end
          if (cur_wen >= 0) begin
            checks++;
            if (obs_wen != cur_wen) begin errors++; $display("FAIL wen_count got=%0d want=%0d", obs_wen, cur_wen); end
          end
          if (cur_pop31 >= 0) begin
            checks++;
            if (obs_pop31 != cur_pop31) begin errors++; $display("FAIL pop31_count got=%0d want=%0d", obs_pop31, cur_pop31); end
          end
        end
      end
    end else if (START) begin
      build(int'(M_SIZE_in), int'(K_SIZE_in), int'(N_SIZE_in));
      obs_ren = 0; obs_wen = 0; obs_pop31 = 0;
      cur_ren = lit_ren; cur_wen = lit_wen; cur_pop31 = lit_pop31;
      if (lit_qsize >= 0) begin
        checks++;
        if (q.size() != lit_qsize) begin errors++; $display("FAIL model_len got=%0d want=%0d", q.size(), lit_qsize); end
      end
      if (lit_last >= 0 && q.size() >= 8) begin
        checks++;
        if (q[$].oaddr != lit_last || q[q.size() - 8].oaddr != lit_last - 7 || q[$].cmask != lit_mask) begin
          errors++;
          $display("FAIL model_last_tile got=%0d..%0d mask=%h want=%0d..%0d mask=%h",
                   q[q.size() - 8].oaddr, q[$].oaddr, q[$].cmask, lit_last - 7, lit_last, lit_mask);
        end
      end
      mode = (q.size() == 0) ? 2 : 1;
    end
  end

  task automatic set_lit(int qs, int rn, int wn, int p31, int last, bit [31:0] mk);
    lit_qsize = qs; lit_ren = rn; lit_wen = wn; lit_pop31 = p31; lit_last = last; lit_mask = mk;
  endtask

  task automatic go(int m, int k, int n);
    @(posedge CLK); #1;
    M_SIZE_in = 9'(m); K_SIZE_in = 9'(k); N_SIZE_in = 9'(n); START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (mode != 2 && n < budget) begin @(posedge CLK); n++; end
    if (mode != 2) begin
      $display("FAIL wait_done timeout after %0d cycles", budget);
      $fatal(1, "timeout");
    end
    #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Single full tile.
    set_lit(162, 32, 32, 32, 31, 32'hFFFF_FFFF);
    go(32, 32, 32); wait_done(1000);
    repeat (3) @(posedge CLK);

    // Four ragged tiles.
    set_lit(504, 32, 80, 16, 103, 32'h1);
    go(40, 8, 33); wait_done(2000);

    // Zero dimensions go straight to DONE.
    set_lit(0, -1, -1, -1, -1, '0);
    go(5, 0, 5); repeat (3) @(posedge CLK);
    go(0, 7, 7); repeat (3) @(posedge CLK);

    // Stalls at c=3 and mid-write.
    set_lit(162, 32, 32, 32, -1, '0);
    go(32, 32, 32);
    repeat (4) @(posedge CLK); #1 STALL = 1'b1;
    repeat (5) @(posedge CLK); #1 STALL = 1'b0;
    n = 0;
    while (!OUT_SRAM_WEN_out && n < 500) begin @(posedge CLK); #1; n++; end
    if (n >= 500) begin $display("FAIL wen_wait timeout"); $fatal(1, "timeout"); end
    repeat (10) @(posedge CLK); #1 STALL = 1'b1;
    repeat (5) @(posedge CLK); #1 STALL = 1'b0;
    wait_done(1000);

    // Reset mid-stream, then a clean job.
    set_lit(-1, -1, -1, -1, -1, '0);
    go(32, 32, 32);
    repeat (20) @(posedge CLK); #1 RST = 1'b1;
    repeat (3) @(posedge CLK); #1 RST = 1'b0;
    set_lit(118, 4, 16, 0, -1, '0);
    go(16, 4, 16); wait_done(1000);

    // START during drain is ignored; restart from DONE with new sizes.
    set_lit(162, 32, 32, 32, -1, '0);
    go(32, 32, 32);
    repeat (80) @(posedge CLK); #1;
    M_SIZE_in = 9'd8; K_SIZE_in = 9'd8; N_SIZE_in = 9'd8; START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
    wait_done(1000);
    set_lit(246, 10, 40, 0, -1, '0);
    go(20, 5, 40); wait_done(1000);

    // Random jobs with random stalls and stray STARTs.
    set_lit(-1, -1, -1, -1, -1, '0);
    for (int j = 0; j < 8; j++) begin
      go($urandom_range(0, 90), $urandom_range(0, 40), $urandom_range(0, 90));
      n = 0;
      while (mode != 2 && n < 20000) begin
        STALL = ($urandom_range(0, 5) == 0);
        START = ($urandom_range(0, 30) == 0);
        M_SIZE_in = 9'($urandom_range(0, 90));
        K_SIZE_in = 9'($urandom_range(0, 40));
        N_SIZE_in = 9'($urandom_range(0, 90));
        @(posedge CLK); #1;
        n++;
      end
      START = 1'b0; STALL = 1'b0;
      if (mode != 2) begin $display("FAIL random job %0d timeout", j); $fatal(1, "timeout"); end
      repeat (2) @(posedge CLK);
    end

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
